hash_lookup_arbiter: RTL and testbench
======================================

Name: hash_lookup_arbiter

Overview:
- Shares one single-port hash-bucket memory among NUM_REQ hash-key FIFOs.
- Arbitration is round-robin. Each FIFO presents its head entry as req_valid/req_key and advances on a one-cycle req_pop pulse.
- For each granted request, the block pops the FIFO, folds the key into a bucket address, and issues one read with fixed latency.
- It returns the bucket word, tagged with requester id and key, on a valid/ready response port to the downstream compare stage.

Parameters:
- NUM_REQ, 4, number of requesting FIFOs (2..8).
- ID_WIDTH, 2, width of requester id; must equal clog2(NUM_REQ), minimum 1.
- KEY_WIDTH, 16, hash key width.
- ADDR_WIDTH, 10, bucket memory address width (< KEY_WIDTH).
- DATA_WIDTH, 32, bucket memory word width.
- MEM_LATENCY, 2, cycles from mem_rd_en to valid mem_rd_data (>= 1).

Ports:
- clk, in, 1, clock.
- rstn, in, 1, reset: synchronous, active-low.
- req_valid, in, NUM_REQ, bit i high when FIFO i head holds a valid key.
- req_key, in, NUM_REQ*KEY_WIDTH, head key of FIFO i at bits [i*KEY_WIDTH +: KEY_WIDTH].
- req_pop, out, NUM_REQ, one-hot one-cycle pulse that advances FIFO i.
- mem_rd_en, out, 1, bucket memory read strobe.
- mem_addr, out, ADDR_WIDTH, bucket address.
- mem_rd_data, in, DATA_WIDTH, bucket word, valid MEM_LATENCY cycles after mem_rd_en.
- rsp_valid, out, 1, response valid.
- rsp_ready, in, 1, downstream accepts response.
- rsp_id, out, ID_WIDTH, requester index of response.
- rsp_key, out, KEY_WIDTH, key that was looked up.
- rsp_data, out, DATA_WIDTH, captured bucket word.
- busy, out, 1, high whenever state != IDLE.
- lookup_count, out, 16, completed lookups, wraps at 0xFFFF -> 0.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. One lookup in flight at a time.
- Reset (rstn low at a clock edge):
  - state = IDLE; rr_last = NUM_REQ-1, so requester 0 has top priority after reset.
  - Wait counter and lookup_count = 0.
  - rsp_valid, rsp_id, rsp_key, rsp_data = 0; req_pop = 0; mem_rd_en = 0; mem_addr = 0.
  - Reset mid-operation abandons the lookup: no pop or read is issued afterwards, and any in-flight memory data is ignored.
- IDLE, cycle t0, any req_valid high:
  - Grant g = first i with req_valid[i], searching from (rr_last+1) mod NUM_REQ upward with wrap.
  - At the edge, latch g and req_key[g]; go to ISSUE.
  - Keys are latched before the pop, so FIFO head data is captured intact.
- ISSUE, cycle t0+1:
  - req_pop[g] = 1 and mem_rd_en = 1, both decoded from state; exactly one cycle each.
  - mem_addr = key[ADDR_WIDTH-1:0] XOR zero-extended key[KEY_WIDTH-1:ADDR_WIDTH] (folded address).
  - Load wait counter with MEM_LATENCY; go to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - On the cycle counter == 1, capture mem_rd_data into rsp_data (this is cycle t0+1+MEM_LATENCY).
  - Go to RESP.
- RESP:
  - rsp_valid = 1 from cycle t0+2+MEM_LATENCY; rsp_id = g, rsp_key = latched key.
  - All rsp_* outputs stay stable while rsp_ready is low.
  - On rsp_valid && rsp_ready: rr_last <= g, lookup_count += 1, go to IDLE.
  - Next grant decision is in the following cycle, so back-to-back lookups are spaced MEM_LATENCY+3 cycles apart.
- mem_addr holds its last value outside ISSUE; memory ignores it when mem_rd_en is low.
- req_valid changes outside IDLE are ignored. Requests arriving during a lookup wait; a request is never dropped.
- Starvation freedom: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...
- Fairness pointer updates only on response handshake, never on grant.
- rsp_ready high before rsp_valid has no effect.

Test Plan:
- Reset then req_valid=4'b0001 with key 0xFC05 at t0:
  - req_pop=4'b0001 and mem_rd_en=1 at t0+1, mem_addr=0x03A.
  - Memory returns 0xDEADBEEF at t0+3; rsp_valid at t0+4 with id=0, key=0xFC05, data=0xDEADBEEF; lookup_count=1.
- req_valid=4'b1111 held, rsp_ready=1 → grant order 0,1,2,3,0; each req_pop one-hot, single cycle; lookups spaced 5 cycles apart.
- rr_last=1, req_valid=4'b0101 → grant 2, then 0; req_valid=4'b0001 only → grant 0 repeatedly.
- rsp_ready low 10 cycles in RESP → rsp_valid, rsp_id, rsp_key, rsp_data unchanged; no req_pop or mem_rd_en; busy=1; completes on first ready cycle.
- rstn low during WAIT → all outputs 0 the next cycle, state IDLE; with req_valid=4'b0010 afterwards, requester 1 is granted with no stale response emitted.
- MEM_LATENCY=1 and MEM_LATENCY=4 builds → rsp_data equals memory word at t0+2 / t0+5; rsp_valid at t0+3 / t0+6.

Source files
------------

// File: rtl/hash_lookup_arbiter_if.sv
// Bundles the requester FIFO heads, the bucket memory read port and the response port.
// The arbiter drives through the master modport and the surrounding logic uses slave.
interface hash_lookup_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int KEY_WIDTH  = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*KEY_WIDTH-1:0] req_key;
    logic [NUM_REQ-1:0]           req_pop;
    logic                         mem_rd_en;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [DATA_WIDTH-1:0]        mem_rd_data;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_WIDTH-1:0]          rsp_id;
    logic [KEY_WIDTH-1:0]         rsp_key;
    logic [DATA_WIDTH-1:0]        rsp_data;

    modport master (
        input  req_valid, req_key, mem_rd_data, rsp_ready,
        output req_pop, mem_rd_en, mem_addr, rsp_valid, rsp_id, rsp_key, rsp_data
    );

    modport slave (
        output req_valid, req_key, mem_rd_data, rsp_ready,
        input  req_pop, mem_rd_en, mem_addr, rsp_valid, rsp_id, rsp_key, rsp_data
    );
endinterface

// File: rtl/hash_lookup_arbiter.sv
// Round-robin arbiter sharing one fixed-latency bucket memory among NUM_REQ key FIFOs,
// running one lookup at a time through IDLE -> ISSUE -> WAIT -> RESP.
module hash_lookup_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int KEY_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    hash_lookup_arbiter_if.master bus,
    output logic                  busy,
    output logic [15:0]           lookup_count
);
    localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_last_q, rr_last_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [15:0]             count_q, count_d;

    logic [ID_WIDTH-1:0]     gnt_c;
    logic                    any_c;
    logic [KEY_WIDTH-1:0]    head_key_c;

    function automatic logic [ADDR_WIDTH-1:0] fold(input logic [KEY_WIDTH-1:0] k);
        return k[ADDR_WIDTH-1:0] ^ ADDR_WIDTH'(k[KEY_WIDTH-1:ADDR_WIDTH]);
    endfunction

    // Scan from the highest offset down so the last hit is the nearest one after rr_last.
    always_comb begin
        int idx;
        gnt_c = '0;
        any_c = 1'b0;
        idx   = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(rr_last_q) + i) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                gnt_c = ID_WIDTH'(idx);
                any_c = 1'b1;
            end
        end
    end

    assign head_key_c = bus.req_key[int'(gnt_c)*KEY_WIDTH +: KEY_WIDTH];

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        grant_d    = grant_q;
        key_d      = key_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    grant_d    = gnt_c;
                    key_d      = head_key_c;
                    mem_addr_d = fold(head_key_c);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d = bus.mem_rd_data;
                    state_d    = RESP;
                end
            end
            RESP: begin
                // Fairness pointer moves only once the response is consumed.
                if (bus.rsp_ready) begin
                    rr_last_d = grant_q;
                    count_d   = count_q + 16'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rr_last_q  <= ID_WIDTH'(NUM_REQ - 1);
            grant_q    <= '0;
            key_q      <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            grant_q    <= grant_d;
            key_q      <= key_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            count_q    <= count_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pop
        assign bus.req_pop[gi] = (state_q == ISSUE) && (grant_q == ID_WIDTH'(gi));
    end

    assign bus.mem_rd_en = (state_q == ISSUE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = grant_q;
    assign bus.rsp_key   = key_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE);
    assign lookup_count  = count_q;
endmodule

// File: tb/tb_hash_lookup_arbiter.sv
// Directed bench for hash_lookup_arbiter: rotation, fairness, backpressure and mid-lookup reset,
// against a fixed-latency bucket memory model.
module tb_hash_lookup_arbiter;
    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int KW  = 16;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        busy;
    logic [15:0] lookup_count;

    hash_lookup_arbiter_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .KEY_WIDTH(KW),
                             .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    hash_lookup_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IW), .KEY_WIDTH(KW), .ADDR_WIDTH(AW),
                          .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .busy         (busy),
        .lookup_count (lookup_count)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] fold(input logic [KW-1:0] k);
        return k[AW-1:0] ^ AW'(k[KW-1:AW]);
    endfunction

    // Bucket contents: 0x03A holds 0xDEADBEEF, other addresses differ by their offset from it.
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {22'b0, a ^ 10'h03A};
    endfunction

    logic [LAT-1:0] pv = '0;
    logic [DW-1:0]  pd [LAT];
    always @(posedge clk) begin
        pv[0] <= bus.mem_rd_en;
        pd[0] <= memf(bus.mem_addr);
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign bus.mem_rd_data = pv[LAT-1] ? pd[LAT-1] : 32'h0BAD0BAD;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_count;
    logic [KW-1:0] keys [NR];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_keys();
        for (int i = 0; i < NR; i++) bus.req_key[i*KW +: KW] = keys[i];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the IDLE cycle t0 with req_valid already driven; returns in the next IDLE cycle.
    task automatic lookup(input int id, input int stall);
        logic [KW-1:0] k;
        logic [AW-1:0] a;
        k = keys[id];
        a = fold(k);
        tick();
        check("pop_t1", bus.req_pop, 64'(1) << id);
        check("rden_t1", bus.mem_rd_en, 1);
        check("addr_t1", bus.mem_addr, a);
        check("busy_t1", busy, 1);
        keys[id] = keys[id] + 16'h0111;
        drive_keys();
        tick();
        check("pop_t2", bus.req_pop, 0);
        check("rden_t2", bus.mem_rd_en, 0);
        check("addr_hold", bus.mem_addr, a);
        tick();
        check("valid_t3", bus.rsp_valid, 0);
        tick();
        check("valid_t4", bus.rsp_valid, 1);
        check("id", bus.rsp_id, id);
        check("key", bus.rsp_key, k);
        check("data", bus.rsp_data, memf(a));
        check("count_pre", lookup_count, exp_count);
        for (int s = 1; s < stall; s++) begin
            tick();
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_id", bus.rsp_id, id);
            check("stall_key", bus.rsp_key, k);
            check("stall_data", bus.rsp_data, memf(a));
            check("stall_pop", bus.req_pop, 0);
            check("stall_rden", bus.mem_rd_en, 0);
            check("stall_busy", busy, 1);
        end
        if (stall > 0) bus.rsp_ready = 1'b1;
        tick();
        exp_count = exp_count + 16'd1;
        check("valid_done", bus.rsp_valid, 0);
        check("busy_done", busy, 0);
        check("count", lookup_count, exp_count);
        $display("lookup id=%0d key=%04h addr=%03h data=%08h count=%0d",
                 id, k, a, memf(a), exp_count);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pop"}, bus.req_pop, 0);
        check({tag, "_rden"}, bus.mem_rd_en, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_valid"}, bus.rsp_valid, 0);
        check({tag, "_id"}, bus.rsp_id, 0);
        check({tag, "_key"}, bus.rsp_key, 0);
        check({tag, "_data"}, bus.rsp_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_count"}, lookup_count, 0);
    endtask

    initial begin
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        keys[0] = 16'hFC05;
        keys[1] = 16'h1234;
        keys[2] = 16'hABCD;
        keys[3] = 16'h0F0F;
        drive_keys();
        exp_count = 16'd0;
        tick();
        tick();
        check_reset_state("reset");
        rstn = 1'b1;

        // Single lookup: key 0xFC05 folds to 0x03A, bucket word 0xDEADBEEF.
        bus.req_valid = 4'b0001;
        lookup(0, 0);
        bus.req_valid = 4'b0000;
        tick();
        check("idle_nopop", bus.req_pop, 0);

        // Fresh reset so requester 0 leads the rotation.
        rstn = 1'b0;
        tick();
        check("rst2_count", lookup_count, 0);
        rstn = 1'b1;
        exp_count = 16'd0;
        bus.req_valid = 4'b1111;
        lookup(0, 0);
        lookup(1, 0);
        lookup(2, 0);
        lookup(3, 0);
        lookup(0, 0);

        bus.req_valid = 4'b0010;
        lookup(1, 0);
        bus.req_valid = 4'b0101;
        lookup(2, 0);
        lookup(0, 0);
        bus.req_valid = 4'b0001;
        lookup(0, 0);
        lookup(0, 0);

        // Backpressure: ten cycles of rsp_ready low in RESP with every requester pending.
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b0;
        lookup(1, 10);

        // Reset while in WAIT abandons the lookup.
        bus.req_valid = 4'b0001;
        tick();
        check("abort_pop", bus.req_pop, 4'b0001);
        check("abort_rden", bus.mem_rd_en, 1);
        tick();
        check("abort_wait_busy", busy, 1);
        rstn = 1'b0;
        bus.req_valid = 4'b0000;
        tick();
        check_reset_state("abort");
        rstn = 1'b1;
        exp_count = 16'd0;
        bus.req_valid = 4'b0010;
        lookup(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
